log_weight_encoder: RTL

- Converts a stream of 8-bit two's-complement kernel weights into the sign/exponent shift codes used by the shift-based approximate multipliers of the 9-multiplier convolution datapath.
- Collects one kernel of N weights and emits it as a packed code word, together with the kernel's summed absolute quantization error.
- Sits between the weight loader and the multiplier array. It is the encoding end of the shift-code interface the multipliers consume.

---
 rtl/log_weight_encoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/log_weight_encoder.sv
// Packs a kernel of N signed weights into sign/exponent shift codes for the shift multipliers,
// together with the kernel's summed absolute quantization error.
module log_weight_encoder #(
    parameter int unsigned N     = 9,
    parameter int unsigned ERR_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic [7:0]         in_weight,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [5*N-1:0]     out_codes,
    output logic [ERR_W-1:0]   out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned SUM_W = ((ERR_W > 10) ? ERR_W : 10) + 1;

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5*N-1:0]     codes_q, codes_d;
    logic [ERR_W-1:0]   acc_q, acc_d;

    // Per-weight encoding
    logic [8:0] w_ext, mag;
    logic       w_sign, w_zero, round_up;
    logic [3:0] lead;
    logic [9:0] pow_lo, pow_hi, below, above, enc_err;
    logic [2:0] enc_exp;
    logic [4:0] enc_code;

    always_comb begin
        w_sign = in_weight[7];
        w_ext  = {in_weight[7], in_weight};
        mag    = w_sign ? (~w_ext + 9'd1) : w_ext;
        w_zero = (mag == 9'd0);
        lead   = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (mag[i]) lead = 4'(i);
        end
        pow_lo   = 10'd1 << lead;
        pow_hi   = 10'd1 << (lead + 4'd1);
        below    = {1'b0, mag} - pow_lo;
        above    = pow_hi - {1'b0, mag};
        // Strict compare: ties round toward the smaller exponent
        round_up = (below > above);
        enc_exp  = round_up ? 3'(lead + 4'd1) : lead[2:0];
        enc_err  = round_up ? above : below;
        if (w_zero) begin
            enc_code = 5'b10000;
            enc_err  = 10'd0;
        end else begin
            enc_code = {1'b0, w_sign, enc_exp};
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: begin
                if (!clr && in_valid && (cnt_q == CNT_W'(N - 1))) state_d = StHold;
            end
            StHold: begin
                if (clr || out_ready) state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StCollect: in_ready  = 1'b1;
            StHold:    out_valid = 1'b1;
            default:   in_ready  = 1'b0;
        endcase
    end

    // Slot, counter and error accumulator datapath
    logic             accept, flush, sat;
    logic [SUM_W-1:0] sum;

    always_comb begin
        accept  = (state_q == StCollect) && in_valid && !clr;
        flush   = clr || ((state_q == StHold) && out_ready);
        sum     = SUM_W'(acc_q) + SUM_W'(enc_err);
        sat     = (sum > SUM_W'({ERR_W{1'b1}}));
        cnt_d   = cnt_q;
        codes_d = codes_q;
        acc_d   = acc_q;
        if (flush) begin
            cnt_d   = '0;
            codes_d = '0;
            acc_d   = '0;
        end else if (accept) begin
            cnt_d                        = cnt_q + CNT_W'(1);
            codes_d[5*int'(cnt_q) +: 5] = enc_code;
            acc_d                        = sat ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            codes_q <= '0;
            acc_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            codes_q <= codes_d;
            acc_q   <= acc_d;
        end
    end

    assign out_codes = codes_q;
    assign out_err   = acc_q;

endmodule
